// File: rtl/tex_refill_arbiter.sv
// Round-robin refill arbiter: shares one burst read port among several texture-cache miss ports,
// assembles the returned beats into a line and pulses the response back to the winner only.
module tex_refill_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned LINE_BYTES = 64,
  parameter int unsigned BEAT_BITS  = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      miss_valid,
  input  logic [NUM_REQ*32-1:0]   miss_addr,
  output logic [NUM_REQ-1:0]      miss_ready,
  output logic [NUM_REQ-1:0]      miss_resp_valid,
  output logic [LINE_BYTES*8-1:0] miss_resp_data,
  output logic                    mem_req_valid,
  output logic [31:0]             mem_req_addr,
  output logic [7:0]              mem_req_beats,
  input  logic                    mem_req_ready,
  input  logic                    mem_rdata_valid,
  input  logic [BEAT_BITS-1:0]    mem_rdata,
  input  logic                    mem_rdata_last,
  output logic                    busy,
  output logic                    protocol_err
);

  localparam int unsigned LINE_BITS = LINE_BYTES * 8;
  localparam int unsigned BEATS     = LINE_BITS / BEAT_BITS;
  localparam int unsigned PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [CNT_W-1:0] LAST_BEAT   = CNT_W'(BEATS - 1);
  localparam logic [PTR_W-1:0] LAST_REQ    = PTR_W'(NUM_REQ - 1);
  localparam logic [31:0]      OFFSET_MASK = 32'(LINE_BYTES - 1);

  typedef enum logic [1:0] {StIdle, StReq, StData, StResp} state_e;

  state_e               state_q;
  logic [PTR_W-1:0]     rr_ptr_q;
  logic [PTR_W-1:0]     grant_q;
  logic [NUM_REQ-1:0]   mask_q;
  logic [CNT_W-1:0]     beat_cnt_q;
  logic [31:0]          req_addr_q;
  logic                 req_valid_q;
  logic                 busy_q;
  logic                 err_q;
  logic [NUM_REQ-1:0]   resp_valid_q;
  logic [BEAT_BITS-1:0] line_q [BEATS];

  logic [31:0]          addr_slot [NUM_REQ];
  logic [NUM_REQ-1:0]   eligible;
  logic                 grant_any;
  logic [PTR_W-1:0]     grant_idx;
  logic [PTR_W-1:0]     scan_idx;
  logic [NUM_REQ-1:0]   grant_oh;
  logic [NUM_REQ-1:0]   owner_oh;
  logic                 final_beat;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_slot[i] = miss_addr[i*32 +: 32];
    end
  end

  // Scan from rr_ptr upward with wrap; first eligible requester wins.
  always_comb begin
    eligible  = miss_valid & ~mask_q;
    grant_any = 1'b0;
    grant_idx = rr_ptr_q;
    scan_idx  = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_any && eligible[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
      scan_idx = (scan_idx == LAST_REQ) ? '0 : scan_idx + PTR_W'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_oh[i] = grant_any && (grant_idx == PTR_W'(i));
      owner_oh[i] = (grant_q == PTR_W'(i));
    end
  end

  assign final_beat = (beat_cnt_q == LAST_BEAT);

  // Accept pulse is combinational so the requester sees it in the grant cycle itself.
  assign miss_ready      = (state_q == StIdle && !rst) ? grant_oh : '0;
  assign miss_resp_valid = resp_valid_q;
  assign mem_req_valid   = req_valid_q;
  assign mem_req_addr    = req_addr_q;
  assign mem_req_beats   = 8'(BEATS);
  assign busy            = busy_q;
  assign protocol_err    = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      mask_q       <= '0;
      beat_cnt_q   <= '0;
      req_addr_q   <= '0;
      req_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      resp_valid_q <= '0;
    end else begin
      mask_q       <= '0;
      resp_valid_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (grant_any) begin
            grant_q     <= grant_idx;
            req_addr_q  <= addr_slot[grant_idx] & ~OFFSET_MASK;
            rr_ptr_q    <= (grant_idx == LAST_REQ) ? '0 : grant_idx + PTR_W'(1);
            req_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= StReq;
          end
        end
        StReq: begin
          if (mem_req_ready) begin
            req_valid_q <= 1'b0;
            beat_cnt_q  <= '0;
            state_q     <= StData;
          end
        end
        StData: begin
          if (mem_rdata_valid) begin
            // Beat count decides completion; a wrong last flag is only reported.
            if (mem_rdata_last != final_beat) begin
              err_q <= 1'b1;
            end
            if (final_beat) begin
              beat_cnt_q   <= '0;
              resp_valid_q <= owner_oh;
              state_q      <= StResp;
            end else begin
              beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            end
          end
        end
        StResp: begin
          mask_q  <= owner_oh;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Line buffer has no reset; it keeps the last line until new beats land.
  always_ff @(posedge clk) begin
    if (!rst && state_q == StData && mem_rdata_valid) begin
      line_q[beat_cnt_q] <= mem_rdata;
    end
  end

  always_comb begin
    for (int b = 0; b < BEATS; b++) begin
      miss_resp_data[b*BEAT_BITS +: BEAT_BITS] = line_q[b];
    end
  end

endmodule

// File: tb/tb_tex_refill_arbiter.sv
// Bench for tex_refill_arbiter: table vectors, directed corner sequences and random traffic,
// all checked every cycle against a transaction-level reference model.
module tb_tex_refill_arbiter;

  localparam int NR    = 2;
  localparam int LB    = 64;
  localparam int BB    = 64;
  localparam int BEATS = LB * 8 / BB;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   miss_valid;
  logic [NR*32-1:0] miss_addr;
  logic [NR-1:0]   miss_ready;
  logic [NR-1:0]   miss_resp_valid;
  logic [LB*8-1:0] miss_resp_data;
  logic            mem_req_valid;
  logic [31:0]     mem_req_addr;
  logic [7:0]      mem_req_beats;
  logic            mem_req_ready;
  logic            mem_rdata_valid;
  logic [BB-1:0]   mem_rdata;
  logic            mem_rdata_last;
  logic            busy;
  logic            protocol_err;

  always #5 clk = ~clk;

  tex_refill_arbiter #(.NUM_REQ(NR), .LINE_BYTES(LB), .BEAT_BITS(BB)) dut (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ready(miss_ready),
    .miss_resp_valid(miss_resp_valid), .miss_resp_data(miss_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_beats(mem_req_beats),
    .mem_req_ready(mem_req_ready), .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
    .mem_rdata_last(mem_rdata_last), .busy(busy), .protocol_err(protocol_err)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: one refill outstanding, tracked as phases of a transaction.
  bit           m_inflight, m_req_pend, m_data_phase, m_resp_due, m_err;
  int           m_g, m_rr, m_nb;
  logic [NR-1:0] m_mask;
  logic [31:0]  m_addr;
  logic [LB*8-1:0] m_line;

  // Stimulus controls.
  logic [31:0] a [NR];
  logic [NR-1:0] mv;
  bit  auto_req, gap_alt, gap_tog, data_idx;
  int  new_pct, ready_pct, beat_pct, lag_pct, bad_last_idx, bp_hold, stray_cnt;
  bit  keep [NR];
  bit  done [NR];
  int  lag [NR];

  // Observations.
  int  cyc, resp_cnt, grant_cnt, req_cycles, beats_sent, grant_cyc, resp_cyc;
  int  obs_grants[$];
  logic [NR-1:0]  last_ready;
  logic [31:0]    last_req_addr;
  logic [LB*8-1:0] last_resp_data;

  typedef struct {
    logic [NR-1:0] mv;
    logic [31:0]   a0;
    logic [31:0]   a1;
    logic [NR-1:0] exp_ready;
    logic [31:0]   exp_addr;
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input logic [LB*8-1:0] act, input logic [LB*8-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] align(input logic [31:0] x);
    return (x / LB) * LB;
  endfunction

  function automatic int rr_pick(input logic [NR-1:0] elig, input int rr);
    for (int k = 0; k < NR; k++) begin
      if (elig[(rr + k) % NR]) return (rr + k) % NR;
    end
    return -1;
  endfunction

  task automatic drive();
    bit v;
    for (int i = 0; i < NR; i++) begin
      if (done[i]) begin
        if (lag[i] > 0) lag[i]--;
        else begin
          done[i] = 1'b0;
          if (!keep[i]) mv[i] = 1'b0;
        end
      end else if (auto_req && !mv[i] && $urandom_range(99) < new_pct) begin
        mv[i] = 1'b1;
        a[i]  = $urandom;
      end
    end
    miss_valid = mv;
    miss_addr  = {a[1], a[0]};
    if (bp_hold > 0) begin
      mem_req_ready = 1'b0;
      if (m_req_pend) bp_hold--;
    end else begin
      mem_req_ready = ($urandom_range(99) < ready_pct);
    end
    mem_rdata_valid = 1'b0;
    mem_rdata_last  = 1'b0;
    mem_rdata       = {$urandom, $urandom};
    if (m_data_phase) begin
      v = gap_alt ? gap_tog : ($urandom_range(99) < beat_pct);
      if (gap_alt) gap_tog = !gap_tog;
      if (v) begin
        mem_rdata_valid = 1'b1;
        if (data_idx) mem_rdata = 64'(m_nb);
        mem_rdata_last  = (m_nb == BEATS - 1) != (m_nb == bad_last_idx);
        beats_sent++;
      end
    end else if (stray_cnt > 0) begin
      mem_rdata_valid = 1'b1;
      mem_rdata_last  = 1'($urandom_range(1));
      stray_cnt--;
    end
  endtask

  // One clock cycle: drive, check against the model, advance the model, cross the edge.
  task automatic step();
    int exp_g;
    logic [NR-1:0] exp_ready, exp_resp, mask_next;
    drive();
    #1;
    exp_g     = m_inflight ? -1 : rr_pick(miss_valid & ~m_mask, m_rr);
    exp_ready = (exp_g >= 0) ? NR'(1 << exp_g) : '0;
    exp_resp  = m_resp_due ? NR'(1 << m_g) : '0;
    check("miss_ready", miss_ready, exp_ready);
    check("busy", busy, m_inflight);
    check("mem_req_valid", mem_req_valid, m_req_pend);
    if (m_req_pend) begin
      check("mem_req_addr", mem_req_addr, m_addr);
      check("mem_req_beats", mem_req_beats, BEATS);
      req_cycles++;
      last_req_addr = mem_req_addr;
    end
    check("miss_resp_valid", miss_resp_valid, exp_resp);
    if (m_resp_due) check("miss_resp_data", miss_resp_data, m_line);
    check("protocol_err", protocol_err, m_err);
    last_ready = miss_ready;
    if (miss_ready != '0) begin
      grant_cnt++;
      grant_cyc = cyc;
      obs_grants.push_back(miss_ready[1] ? 1 : 0);
    end
    for (int i = 0; i < NR; i++) begin
      if (miss_resp_valid[i]) begin
        done[i] = 1'b1;
        lag[i]  = ($urandom_range(99) < lag_pct) ? 1 : 0;
        resp_cnt++;
        resp_cyc = cyc;
        last_resp_data = miss_resp_data;
      end
    end
    mask_next = '0;
    if (m_resp_due) begin
      m_resp_due = 1'b0;
      m_inflight = 1'b0;
      mask_next  = NR'(1 << m_g);
    end else if (!m_inflight) begin
      if (exp_g >= 0) begin
        m_inflight = 1'b1;
        m_g        = exp_g;
        m_rr       = (exp_g + 1) % NR;
        m_req_pend = 1'b1;
        m_addr     = align(a[exp_g]);
      end
    end else if (m_req_pend) begin
      if (mem_req_ready) begin
        m_req_pend   = 1'b0;
        m_data_phase = 1'b1;
        m_nb         = 0;
      end
    end else if (m_data_phase && mem_rdata_valid) begin
      if (mem_rdata_last != (m_nb == BEATS - 1)) m_err = 1'b1;
      m_line[m_nb*BB +: BB] = mem_rdata;
      m_nb++;
      if (m_nb == BEATS) begin
        m_data_phase = 1'b0;
        m_resp_due   = 1'b1;
      end
    end
    m_mask = mask_next;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    miss_valid = mv;
    mem_req_ready = 1'b0;
    mem_rdata_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rst_miss_ready", miss_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_resp_valid", miss_resp_valid, 0);
    check("rst_protocol_err", protocol_err, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    {m_inflight, m_req_pend, m_data_phase, m_resp_due, m_err} = '0;
    m_rr = 0; m_nb = 0; m_g = 0; m_mask = '0;
    gap_tog = 1'b0;
    for (int i = 0; i < NR; i++) begin
      done[i] = 1'b0;
      lag[i]  = 0;
    end
  endtask

  task automatic run_until_resp(input int budget, input string nm);
    int start, n;
    start = resp_cnt;
    n = 0;
    while (resp_cnt == start && n < budget) begin
      step();
      n++;
    end
    n_cmp++;
    if (resp_cnt == start) begin
      n_fail++;
      $display("FAIL %s: no response within %0d cycles", nm, budget);
    end
  endtask

  initial begin
    int r0, g0, rc, bs, n;
    vecs[0] = '{2'b01, 32'h0000_1234, 32'h0000_0000, 2'b01, 32'h0000_1200};
    vecs[1] = '{2'b10, 32'h0000_0000, 32'hABCD_EF7F, 2'b10, 32'hABCD_EF40};
    vecs[2] = '{2'b11, 32'h0000_0040, 32'h0000_0080, 2'b01, 32'h0000_0040};
    vecs[3] = '{2'b10, 32'h0000_0000, 32'hFFFF_FFFF, 2'b10, 32'hFFFF_FFC0};
    vecs[4] = '{2'b01, 32'h8000_003F, 32'h0000_0000, 2'b01, 32'h8000_0000};

    rst = 1'b1; mv = '0; a[0] = '0; a[1] = '0;
    miss_valid = '0; miss_addr = '0; mem_req_ready = 1'b0;
    mem_rdata_valid = 1'b0; mem_rdata = '0; mem_rdata_last = 1'b0;
    auto_req = 1'b0; gap_alt = 1'b0; data_idx = 1'b1; bad_last_idx = -1;
    new_pct = 0; ready_pct = 100; beat_pct = 100; lag_pct = 0; bp_hold = 0; stray_cnt = 0;
    keep[0] = 1'b0; keep[1] = 1'b0;
    cyc = 0; resp_cnt = 0; grant_cnt = 0; req_cycles = 0; beats_sent = 0;
    @(posedge clk);
    #1;
    do_reset();

    // Table vectors: first grant and aligned burst address from a fresh reset.
    for (int t = 0; t < 5; t++) begin
      mv = '0;
      do_reset();
      mv = vecs[t].mv; a[0] = vecs[t].a0; a[1] = vecs[t].a1;
      step();
      check("tbl_grant", last_ready, vecs[t].exp_ready);
      run_until_resp(40, "tbl_resp");
      check("tbl_addr", last_req_addr, vecs[t].exp_addr);
      repeat (3) step();
      mv = '0;
      repeat (14) step();
    end

    // Single miss with indexed beats: latency, data placement, single pulse.
    mv = '0;
    do_reset();
    r0 = resp_cnt;
    mv = 2'b01; a[0] = 32'h0000_1234;
    run_until_resp(40, "single_resp");
    repeat (4) step();
    check("single_addr", last_req_addr, 32'h0000_1200);
    check("single_pulses", resp_cnt - r0, 1);
    check("single_data_lo", last_resp_data[63:0], 64'h0);
    check("single_data_hi", last_resp_data[511:448], 64'h7);
    check("single_latency", resp_cyc - grant_cyc, 2 + BEATS);

    // Contention at reset exit; req0 keeps asking so round-robin must wrap.
    mv = 2'b11; a[0] = 32'h0000_0100; a[1] = 32'h0000_0200; keep[0] = 1'b1;
    do_reset();
    obs_grants.delete();
    n = 0;
    while (obs_grants.size() < 3 && n < 100) begin
      step();
      n++;
    end
    check("rr_grant_count", obs_grants.size() >= 3, 1);
    if (obs_grants.size() >= 3) begin
      check("rr_first", obs_grants[0], 0);
      check("rr_second", obs_grants[1], 1);
      check("rr_third", obs_grants[2], 0);
    end
    keep[0] = 1'b0;
    run_until_resp(40, "rr_drain");
    repeat (3) step();

    // Memory backpressure for 5 cycles while the request is up.
    data_idx = 1'b0;
    g0 = grant_cnt; rc = req_cycles; bp_hold = 5;
    mv = 2'b01; a[0] = 32'h5555_5555;
    run_until_resp(60, "bp_resp");
    repeat (3) step();
    check("bp_req_cycles", req_cycles - rc, 6);
    check("bp_grants", grant_cnt - g0, 1);

    // Gapped beats every other cycle.
    gap_alt = 1'b1;
    bs = beats_sent; r0 = resp_cnt;
    mv = 2'b10; a[1] = 32'h0ABC_0000;
    run_until_resp(60, "gap_resp");
    repeat (3) step();
    check("gap_beats", beats_sent - bs, BEATS);
    check("gap_pulses", resp_cnt - r0, 1);
    gap_alt = 1'b0;

    // Early last flag on beat 3: error latches, transfer still completes.
    bad_last_idx = 3; r0 = resp_cnt;
    mv = 2'b01; a[0] = 32'h0000_3000;
    run_until_resp(40, "badlast_resp");
    check("badlast_err", protocol_err, 1);
    check("badlast_pulses", resp_cnt - r0, 1);
    bad_last_idx = -1;
    repeat (2) step();
    mv = 2'b10; a[1] = 32'h0000_4000;
    run_until_resp(40, "badlast_next");
    check("badlast_sticky", protocol_err, 1);
    repeat (3) step();

    // Reset after 4 beats, then stray beats while idle.
    mv = 2'b01; a[0] = 32'h0000_6000;
    n = 0;
    while (!(m_data_phase && m_nb == 4) && n < 40) begin
      step();
      n++;
    end
    check("midrst_reached", m_data_phase && m_nb == 4, 1);
    mv = '0;
    do_reset();
    r0 = resp_cnt;
    stray_cnt = 4;
    repeat (6) step();
    check("midrst_no_pulse", resp_cnt - r0, 0);
    mv = 2'b01; a[0] = 32'h0000_7700;
    run_until_resp(40, "midrst_next");
    check("midrst_next_pulses", resp_cnt - r0, 1);
    repeat (3) step();

    // Random traffic.
    mv = '0;
    do_reset();
    r0 = resp_cnt;
    auto_req = 1'b1; new_pct = 30; ready_pct = 60; beat_pct = 70; lag_pct = 50;
    repeat (3000) step();
    check("rand_progress", (resp_cnt - r0) > 20, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
